// File: rtl/hazard_unit_pkg.sv
// Shared pipeline typedefs: register addresses, hazard FSM states and the
// hazard control bundle driven into the pipeline registers.
package hazard_unit_pkg;

    localparam int REG_ADDR_W          = 5;
    localparam int MEM_TIMEOUT_DEFAULT = 256;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic id_ex_stall;
        logic ex_mem_stall;
        logic if_id_flush;
        logic id_ex_bubble;
        logic mem_wb_bubble;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_NONE     = 7'b0000_000;
    localparam hz_ctrl_t CTRL_FREEZE   = 7'b1111_001;
    localparam hz_ctrl_t CTRL_BRANCH   = 7'b0000_110;
    localparam hz_ctrl_t CTRL_LOAD_USE = 7'b1100_010;

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter used for the hazard performance counters; sticks at
// all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: memory-wait freeze with timeout, taken-branch flush and
// load-use stall, plus stall/flush performance counters.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memRead,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_stall,
    output logic             ex_mem_stall,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             mem_wb_bubble,
    output logic             mem_error,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    hz_state_t         fsm_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_wait;
    logic              freeze;
    logic              load_use;
    hz_ctrl_t          ctrl;

    assign mem_wait = mem_req && !mem_ready;
    assign freeze   = mem_wait || (fsm_state == ST_ERR);

    assign load_use = ex_memRead && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    // A branch seen while frozen is dropped here; EX holds it, so it comes
    // back in the first unfrozen cycle.
    always_comb begin
        ctrl = CTRL_NONE;
        if (freeze) begin
            ctrl = CTRL_FREEZE;
        end else if (branch_taken) begin
            ctrl = CTRL_BRANCH;
        end else if (load_use) begin
            ctrl = CTRL_LOAD_USE;
        end
    end

    assign pc_stall      = ctrl.pc_stall;
    assign if_id_stall   = ctrl.if_id_stall;
    assign id_ex_stall   = ctrl.id_ex_stall;
    assign ex_mem_stall  = ctrl.ex_mem_stall;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_ex_bubble  = ctrl.id_ex_bubble;
    assign mem_wb_bubble = ctrl.mem_wb_bubble;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fsm_state <= ST_RUN;
            wait_cnt  <= '0;
            mem_error <= 1'b0;
        end else begin
            case (fsm_state)
                ST_RUN: begin
                    wait_cnt <= '0;
                    if (mem_wait) fsm_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!mem_wait) begin
                        fsm_state <= ST_RUN;
                        wait_cnt  <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        fsm_state <= ST_ERR;
                        mem_error <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ST_ERR: begin
                    mem_error <= 1'b1;
                end
                default: begin
                    fsm_state <= ST_RUN;
                    wait_cnt  <= '0;
                    mem_error <= 1'b0;
                end
            endcase
        end
    end

    assign state = fsm_state;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (pc_stall),
        .count  (stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (if_id_flush),
        .count  (flush_count)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios followed by random traffic, all
// checked against a cycle-level reference model of the hazard rules.
module tb_hazard_unit;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk;
    logic             resetn;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_uses_rs1, id_uses_rs2;
    logic             ex_memRead, branch_taken, mem_req, mem_ready;
    logic             pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic             if_id_flush, id_ex_bubble, mem_wb_bubble, mem_error;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int m_wait_run;
    bit m_err;
    int m_stall;
    int m_flush;

    hazard_unit #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_uses_rs1   (id_uses_rs1),
        .id_uses_rs2   (id_uses_rs2),
        .ex_rd         (ex_rd),
        .ex_memRead    (ex_memRead),
        .branch_taken  (branch_taken),
        .mem_req       (mem_req),
        .mem_ready     (mem_ready),
        .pc_stall      (pc_stall),
        .if_id_stall   (if_id_stall),
        .id_ex_stall   (id_ex_stall),
        .ex_mem_stall  (ex_mem_stall),
        .if_id_flush   (if_id_flush),
        .id_ex_bubble  (id_ex_bubble),
        .mem_wb_bubble (mem_wb_bubble),
        .mem_error     (mem_error),
        .state         (state),
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected control vector {pc,if_id,id_ex,ex_mem stall, flush, id_ex bubble, mem_wb bubble}
    function automatic logic [6:0] model_ctrl();
        bit frozen, lu;
        frozen = (mem_req && !mem_ready) || m_err;
        lu = ex_memRead && (ex_rd != 0) &&
             ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        if (frozen)            return 7'b1111001;
        else if (branch_taken) return 7'b0000110;
        else if (lu)           return 7'b1100010;
        else                   return 7'b0000000;
    endfunction

    function automatic logic [1:0] model_state();
        if (m_err)               return 2'd2;
        else if (m_wait_run > 0) return 2'd1;
        else                     return 2'd0;
    endfunction

    // Check outputs with current inputs applied, then advance one clock and the model.
    task automatic cycle(input string tag);
        logic [6:0] exp_ctrl;
        #1;
        exp_ctrl = model_ctrl();
        check({tag, "_ctrl"}, {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                               if_id_flush, id_ex_bubble, mem_wb_bubble}, exp_ctrl);
        check({tag, "_state"}, state, model_state());
        check({tag, "_mem_error"}, mem_error, m_err);
        check({tag, "_stall_cycles"}, stall_cycles, m_stall);
        check({tag, "_flush_count"}, flush_count, m_flush);
        @(posedge clk);
        if (!resetn) begin
            m_wait_run = 0;
            m_err      = 1'b0;
            m_stall    = 0;
            m_flush    = 0;
        end else begin
            if (exp_ctrl[6] && m_stall < CNT_MAX) m_stall++;
            if (exp_ctrl[2] && m_flush < CNT_MAX) m_flush++;
            if (!m_err) begin
                if (mem_req && !mem_ready) begin
                    if (m_wait_run >= MEM_TIMEOUT) m_err = 1'b1;
                    else m_wait_run++;
                end else begin
                    m_wait_run = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        resetn       = 1'b1;
        id_rs1       = 5'd0;
        id_rs2       = 5'd0;
        id_uses_rs1  = 1'b0;
        id_uses_rs2  = 1'b0;
        ex_rd        = 5'd0;
        ex_memRead   = 1'b0;
        branch_taken = 1'b0;
        mem_req      = 1'b0;
        mem_ready    = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 1'b0;
        cycle("reset");
        resetn = 1'b1;
    endtask

    initial begin
        m_wait_run = 0;
        m_err      = 1'b0;
        m_stall    = 0;
        m_flush    = 0;
        idle_inputs();
        resetn = 1'b0;
        @(negedge clk);
        cycle("reset0");
        cycle("reset1");
        resetn = 1'b1;
        cycle("idle");

        // load-use on rs2: one stall cycle, then the bubble clears ID/EX
        ex_memRead = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
        cycle("lu_hit");
        ex_memRead = 1'b0; ex_rd = 5'd0;
        cycle("lu_after");
        check("lu_stall_cycles", stall_cycles, 1);

        ex_memRead = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
        cycle("lu_x0");
        ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b0;
        cycle("lu_unused");
        check("lu_none_stall_cycles", stall_cycles, 1);

        // branch beats load-use
        ex_memRead = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
        branch_taken = 1'b1;
        cycle("br_lu");
        idle_inputs();
        cycle("br_after");
        check("br_flush_count", flush_count, 1);

        // three memory-wait cycles then completion
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle("mwait");
        check("mwait_state", state, 2'd1);
        mem_ready = 1'b1;
        cycle("mdone");
        mem_req = 1'b0;
        cycle("mrun");
        check("mwait_state_run", state, 2'd0);
        check("mwait_stall_cycles", stall_cycles, 3);

        // branch during freeze is held off until the memory completes
        mem_req = 1'b1; mem_ready = 1'b0; branch_taken = 1'b1;
        cycle("br_frozen");
        mem_ready = 1'b1;
        cycle("br_unfrozen");
        idle_inputs();
        cycle("br_unfrozen_after");
        check("br_frozen_flush_count", flush_count, 1);

        // timeout into ERR, absorbing, then reset
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 7; i++) cycle("tmo");
        check("tmo_state", state, 2'd2);
        check("tmo_mem_error", mem_error, 1);
        mem_ready = 1'b1; mem_req = 1'b0;
        cycle("err_hold");
        check("err_hold_state", state, 2'd2);
        do_reset();
        cycle("err_cleared");
        check("err_reset_state", state, 2'd0);
        check("err_reset_stall_cycles", stall_cycles, 0);

        // stall counter saturation
        ex_memRead = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
        for (int i = 0; i < 20; i++) cycle("sat");
        check("sat_stall_cycles", stall_cycles, CNT_MAX);

        // random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            resetn       = ($urandom_range(0, 59) != 0);
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            ex_rd        = 5'($urandom_range(0, 3));
            id_uses_rs1  = 1'($urandom_range(0, 1));
            id_uses_rs2  = 1'($urandom_range(0, 1));
            ex_memRead   = ($urandom_range(0, 2) == 0);
            branch_taken = ($urandom_range(0, 4) == 0);
            mem_req      = 1'($urandom_range(0, 1));
            mem_ready    = ($urandom_range(0, 9) < 6);
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter MEM_TIMEOUT, default 256: maximum consecutive memory-wait cycles before error.
REQ-002 Parameter CNT_W, default 32: width of the performance counters.
REQ-003 Port clk, input, 1: clock; all state updates on the rising edge.
REQ-004 Port resetn, input, 1: reset, synchronous, active-low.
REQ-005 Port id_rs1 / id_rs2, input, 5 each: source registers of the instruction in ID.
REQ-006 Port id_uses_rs1 / id_uses_rs2, input, 1 each: the ID instruction actually reads that source.
REQ-007 Port ex_rd, input, 5: destination of the ID/EX register output.
REQ-008 Port ex_memRead, input, 1: ID/EX holds a load.
REQ-009 Port branch_taken, input, 1: EX resolved a taken branch or jump this cycle.
REQ-010 Port mem_req / mem_ready, input, 1 each: MEM-stage data access valid / data memory completes this cycle.
REQ-011 Port pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, output, 1 each: hold the PC or pipeline register.
REQ-012 Port if_id_flush, id_ex_bubble, mem_wb_bubble, output, 1 each: clear that register's instruction or control bits.
REQ-013 Port mem_error, output, 1: sticky memory timeout flag.
REQ-014 Port state, output, 2: current FSM state (RUN=0, WAIT=1, ERR=2).
REQ-015 Port stall_cycles / flush_count, output, CNT_W each: performance counters.

Function
REQ-016 freeze SHALL be defined as mem_req && !mem_ready, or state==ERR.
REQ-017 load_use SHALL be defined as ex_memRead && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
REQ-018 Control outputs SHALL be combinational from the current state and inputs, evaluated in priority order freeze > branch_taken > load_use.
REQ-019 On freeze: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall and mem_wb_bubble SHALL be 1; if_id_flush and id_ex_bubble SHALL be 0.
REQ-020 On branch_taken without freeze: if_id_flush=1 and id_ex_bubble=1; every stall output SHALL be 0; load_use SHALL be ignored.
REQ-021 On load_use without freeze or branch: pc_stall=1, if_id_stall=1, id_ex_bubble=1; all other outputs 0; this lasts exactly one cycle per load.
REQ-022 Otherwise all control outputs SHALL be 0.
REQ-023 FSM: RUN->WAIT when mem_req && !mem_ready; WAIT->RUN on the cycle mem_ready=1 or mem_req=0; WAIT->ERR when wait_cnt reaches MEM_TIMEOUT-1 while still waiting; ERR absorbing until reset.
REQ-024 wait_cnt SHALL be cleared in RUN and incremented each WAIT cycle.
REQ-025 mem_error SHALL be 1 iff state==ERR.
REQ-026 stall_cycles SHALL increment in every cycle pc_stall=1; flush_count SHALL increment in every cycle if_id_flush=1.
REQ-027 Both counters SHALL saturate at all-ones; no wrap-around.
REQ-028 A branch_taken arriving during freeze SHALL be suppressed; EX is held, so it is re-presented and applied in the first unfrozen cycle.

Reset
REQ-029 When resetn=0 at a clock edge: state=RUN, wait_cnt=0, mem_error=0, counters=0.
REQ-030 Control outputs SHALL follow REQ-018 during reset from the post-reset state; reset mid-WAIT or in ERR SHALL return the FSM to RUN on the next edge.

Structure
REQ-031 The state enum and MEM_TIMEOUT default SHALL live in the shared pipeline package alongside the other pipeline typedefs.
REQ-032 One sub-module, sat_counter (parameter CNT_W; inputs clk, resetn, inc; output count), SHALL be instantiated twice for the counters.

Verification
REQ-033 ex_memRead=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> exactly one cycle of pc_stall=if_id_stall=id_ex_bubble=1; stall_cycles=1.
REQ-034 Same as REQ-033 with ex_rd=0, or id_uses_rs2=0 -> no stall.
REQ-035 branch_taken=1 together with load_use -> if_id_flush=id_ex_bubble=1, pc_stall=0, flush_count=1.
REQ-036 mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> all four stalls high for 3 cycles, state=WAIT, back to RUN, stall_cycles=3.
REQ-037 MEM_TIMEOUT=4, mem_ready held 0 -> state=ERR and mem_error=1 after 4 WAIT cycles and held; resetn=0 for one edge -> RUN, counters 0.
REQ-038 Force stall_cycles to all-ones (CNT_W=4, 16+ stall cycles) -> counter stays at 15.
